// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WIDTH_MIN = 1;
    localparam int WIDTH_MAX = 64;

    // Bit counter must still be one bit wide for a 1-bit adder.
    function automatic int cnt_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_add_if.sv
// Start/done request bus between a requesting datapath and the serial adder.
interface serial_add_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry_out;

    modport master (
        output start, a, b, carry_in,
        input  busy, done, sum, carry_out
    );

    modport slave (
        input  start, a, b, carry_in,
        output busy, done, sum, carry_out
    );
endinterface

// File: rtl/serial_add_full_adder_cell.sv
// One-bit combinational full adder shared across all bit positions.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/serial_add_controller.sv
// Bit-serial WIDTH-bit adder: one full-adder cell stepped LSB-first with a
// registered carry loop; result and carry are published only on completion.
module serial_add_controller
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         reset,
    serial_add_if.slave  bus
);
    localparam int CNT_W = cnt_w(WIDTH);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] op_a, op_b;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_full;
    logic             carry_reg, cout_q;
    logic [CNT_W-1:0] bit_cnt;
    logic             cell_s, cell_c;
    logic             accept, last;
    logic             busy_c, done_c;

    assign accept = bus.start && ((state == IDLE) || (state == DONE));
    assign last   = (bit_cnt == CNT_W'(WIDTH - 1));

    full_adder_cell u_cell (
        .a    (op_a[0]),
        .b    (op_b[0]),
        .cin  (carry_reg),
        .s    (cell_s),
        .cout (cell_c)
    );

    // The partial sum only stores the WIDTH-1 already-finished bits; the final
    // bit comes straight from the cell on the completion edge.
    generate
        if (WIDTH > 1) begin : g_psum
            logic [WIDTH-2:0] psum;
            always_ff @(posedge clk) begin
                if (reset || accept)
                    psum <= '0;
                else if (state == ADD)
                    psum <= sum_full[WIDTH-1:1];
            end
            assign sum_full = {cell_s, psum};
        end else begin : g_no_psum
            assign sum_full = cell_s;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = ADD;
            ADD:     if (last) state_nxt = DONE;
            DONE:    state_nxt = bus.start ? ADD : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy_c = 1'b0;
        done_c = 1'b0;
        case (state)
            ADD:     busy_c = 1'b1;
            DONE:    done_c = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_a      <= '0;
            op_b      <= '0;
            carry_reg <= 1'b0;
            bit_cnt   <= '0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
        end else if (accept) begin
            op_a      <= bus.a;
            op_b      <= bus.b;
            carry_reg <= bus.carry_in;
            bit_cnt   <= '0;
        end else if (state == ADD) begin
            op_a      <= op_a >> 1;
            op_b      <= op_b >> 1;
            carry_reg <= cell_c;
            bit_cnt   <= bit_cnt + CNT_W'(1);
            if (last) begin
                sum_q  <= sum_full;
                cout_q <= cell_c;
            end
        end
    end

    assign bus.busy      = busy_c;
    assign bus.done      = done_c;
    assign bus.sum       = sum_q;
    assign bus.carry_out = cout_q;

endmodule

// File: tb/tb_serial_add_controller.sv
// Directed checks of the serial adder at WIDTH=8 and WIDTH=1.
module tb_serial_add_controller;

    logic clk = 1'b0;
    logic reset;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    serial_add_if #(.WIDTH(8)) bus8 ();
    serial_add_if #(.WIDTH(1)) bus1 ();

    serial_add_controller #(.WIDTH(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8));
    serial_add_controller #(.WIDTH(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic [7:0] es;
        logic       ec;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One isolated addition starting from IDLE; checks latency, busy window,
    // output hold during ADD and the single-cycle done pulse.
    task automatic do_add8(input vec_t v, input string tag);
        logic       ok;
        logic [8:0] held;
        held = {bus8.carry_out, bus8.sum};
        @(negedge clk);
        bus8.start = 1'b1; bus8.a = v.a; bus8.b = v.b; bus8.carry_in = v.ci;
        @(negedge clk);
        bus8.start = 1'b0; bus8.a = ~v.a; bus8.b = ~v.b; bus8.carry_in = ~v.ci;
        ok = 1'b1;
        for (int j = 0; j < 8; j++) begin
            if (!(bus8.busy === 1'b1 && bus8.done === 1'b0 &&
                  {bus8.carry_out, bus8.sum} === held)) ok = 1'b0;
            @(negedge clk);
        end
        check({tag, " busy_window"}, 64'(ok), 64'd1);
        check({tag, " done"}, 64'(bus8.done), 64'd1);
        check({tag, " busy_end"}, 64'(bus8.busy), 64'd0);
        check({tag, " sum"}, 64'(bus8.sum), 64'(v.es));
        check({tag, " carry_out"}, 64'(bus8.carry_out), 64'(v.ec));
        @(negedge clk);
        check({tag, " done_pulse"}, 64'(bus8.done), 64'd0);
        check({tag, " sum_hold"}, 64'({bus8.carry_out, bus8.sum}), 64'({v.ec, v.es}));
    endtask

    initial begin
        vec_t       vecs[9];
        vec_t       b2b[4];
        logic [1:0] fa_tt[8];
        logic       ok;

        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[6] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};
        vecs[7] = '{8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0};
        vecs[8] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};

        b2b[0] = '{8'h10, 8'h01, 1'b0, 8'h11, 1'b0};
        b2b[1] = '{8'h20, 8'h02, 1'b1, 8'h23, 1'b0};
        b2b[2] = '{8'hFE, 8'h03, 1'b1, 8'h02, 1'b1};
        b2b[3] = '{8'h7F, 8'h81, 1'b0, 8'h00, 1'b1};

        // {carry_out, sum} indexed by {a, b, cin}
        fa_tt = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

        reset = 1'b1;
        bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.carry_in = 1'b0;
        bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.carry_in = 1'b0;
        repeat (2) @(negedge clk);
        check("reset busy", 64'(bus8.busy), 64'd0);
        check("reset done", 64'(bus8.done), 64'd0);
        check("reset sum", 64'({bus8.carry_out, bus8.sum}), 64'd0);
        check("reset w1", 64'({bus1.busy, bus1.done, bus1.carry_out, bus1.sum}), 64'd0);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) do_add8(vecs[i], $sformatf("vec%0d", i));

        // start re-pulsed during ADD must be ignored
        @(negedge clk);
        bus8.start = 1'b1; bus8.a = 8'h11; bus8.b = 8'h22; bus8.carry_in = 1'b0;
        @(negedge clk);
        bus8.start = 1'b0;
        for (int j = 0; j < 8; j++) begin
            if (j == 2) begin
                bus8.start = 1'b1; bus8.a = 8'hF0; bus8.b = 8'h0F; bus8.carry_in = 1'b1;
            end else begin
                bus8.start = 1'b0;
            end
            @(negedge clk);
        end
        bus8.start = 1'b0;
        check("ignore done", 64'(bus8.done), 64'd1);
        check("ignore result", 64'({bus8.carry_out, bus8.sum}), 64'h033);
        ok = 1'b1;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            if (bus8.done !== 1'b0 || bus8.busy !== 1'b0) ok = 1'b0;
        end
        check("ignore no_second_done", 64'(ok), 64'd1);

        // reset in the middle of ADD discards the operation
        @(negedge clk);
        bus8.start = 1'b1; bus8.a = 8'h5A; bus8.b = 8'h3C; bus8.carry_in = 1'b0;
        @(negedge clk);
        bus8.start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midreset busy", 64'(bus8.busy), 64'd0);
        check("midreset done", 64'(bus8.done), 64'd0);
        check("midreset result", 64'({bus8.carry_out, bus8.sum}), 64'd0);
        reset = 1'b0;
        ok = 1'b1;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            if (bus8.done !== 1'b0 || bus8.busy !== 1'b0) ok = 1'b0;
        end
        check("midreset no_done", 64'(ok), 64'd1);
        do_add8(vecs[6], "after_reset");

        // back-to-back with start held high through DONE
        @(negedge clk);
        bus8.start = 1'b1; bus8.a = b2b[0].a; bus8.b = b2b[0].b; bus8.carry_in = b2b[0].ci;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            if (i < 3) begin
                bus8.a = b2b[i+1].a; bus8.b = b2b[i+1].b; bus8.carry_in = b2b[i+1].ci;
            end else begin
                bus8.start = 1'b0;
            end
            ok = 1'b1;
            for (int j = 0; j < 8; j++) begin
                if (bus8.busy !== 1'b1 || bus8.done !== 1'b0) ok = 1'b0;
                @(negedge clk);
            end
            check($sformatf("b2b%0d busy_window", i), 64'(ok), 64'd1);
            check($sformatf("b2b%0d done", i), 64'(bus8.done), 64'd1);
            check($sformatf("b2b%0d result", i), 64'({bus8.carry_out, bus8.sum}),
                  64'({b2b[i].ec, b2b[i].es}));
            @(negedge clk);
        end
        check("b2b idle", 64'({bus8.busy, bus8.done}), 64'd0);

        // WIDTH=1 build: full-adder truth table, done one cycle after accept
        for (int c = 0; c < 8; c++) begin
            logic [2:0] cv;
            cv = 3'(c);
            @(negedge clk);
            bus1.start = 1'b1; bus1.a = cv[2]; bus1.b = cv[1]; bus1.carry_in = cv[0];
            @(negedge clk);
            bus1.start = 1'b0;
            check($sformatf("w1 c%0d busy", c), 64'({bus1.busy, bus1.done}), 64'b10);
            @(negedge clk);
            check($sformatf("w1 c%0d done", c), 64'({bus1.busy, bus1.done}), 64'b01);
            check($sformatf("w1 c%0d result", c), 64'({bus1.carry_out, bus1.sum}), 64'(fa_tt[c]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
